// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the seven-segment display sequencer.
// State encoding and the digit value shown while blanked.
package seg7_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_HI = 2'd1,
        SHOW_LO = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_DIGIT = 4'h0;

endpackage

// File: rtl/seg7_dwell_timer.sv
// Phase dwell counter: counts while running, pulses expire on the
// last cycle of each MAX_COUNT-cycle phase, then wraps to zero.
module seg7_dwell_timer #(
    parameter int unsigned MAX_COUNT = 10_000_000,
    parameter int unsigned CNT_W     = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!run || restart || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Shows each posted byte as high nibble, low nibble, then a blank gap,
// with a one-entry pending buffer in front of the display FSM.
module seg7_scan_ctrl #(
    parameter int unsigned MAX_COUNT = 10_000_000,
    parameter int unsigned CNT_W     = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] val_in,
    input  logic       val_valid,
    output logic       val_ready,
    input  logic       repeat_en,
    output logic [3:0] digit,
    output logic       dp,
    output logic       blank,
    output logic       busy
);

    import seg7_scan_pkg::*;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cur_q;
    logic [7:0] cur_d;
    logic [7:0] pend_q;
    logic [7:0] pend_d;
    logic       pend_valid_q;
    logic       pend_valid_d;
    logic       load;
    logic       expire;
    logic       accept;

    assign val_ready = !pend_valid_q && !rst;
    assign accept    = val_valid && val_ready;

    seg7_dwell_timer #(
        .MAX_COUNT (MAX_COUNT),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state_q != IDLE),
        .restart (load),
        .expire  (expire)
    );

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        load         = 1'b0;

        unique case (state_q)
            IDLE:    load = pend_valid_q;
            SHOW_HI: if (expire) state_d = SHOW_LO;
            SHOW_LO: if (expire) state_d = GAP;
            GAP: begin
                if (expire) begin
                    if (pend_valid_q) begin
                        load = 1'b1;
                    end else if (repeat_en) begin
                        state_d = SHOW_HI;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        // accept needs an empty buffer, so it never collides with a load
        if (load) begin
            cur_d        = pend_q;
            pend_valid_d = 1'b0;
            state_d      = SHOW_HI;
        end
        if (accept) begin
            pend_d       = val_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    always_comb begin
        digit = BLANK_DIGIT;
        dp    = 1'b0;
        blank = 1'b1;
        busy  = (state_q != IDLE);
        unique case (state_q)
            SHOW_HI: begin
                digit = cur_q[7:4];
                dp    = 1'b1;
                blank = 1'b0;
            end
            SHOW_LO: begin
                digit = cur_q[3:0];
                blank = 1'b0;
            end
            IDLE, GAP: ;
        endcase
    end

endmodule
